// File: rtl/capsense_pkg.sv
// Shared types and defaults for the capacitive-touch receive path.
package capsense_pkg;

  localparam int NUM_SENSE_D    = 4;
  localparam int CNT_W_D        = 12;
  localparam int DISCH_CYCLES_D = 500;
  localparam int MAX_COUNT_D    = 4000;
  localparam int CAL_SCANS_D    = 8;
  localparam int THRESHOLD_D    = 40;
  localparam int DEBOUNCE_D     = 3;

  // Calibration counter must be able to hold the value CAL_SCANS itself.
  function automatic int cal_w(input int scans);
    return $clog2(scans + 1);
  endfunction

  localparam int CAL_W_D = cal_w(CAL_SCANS_D);

  typedef enum logic [1:0] {
    IDLE,
    DISCHARGE,
    CHARGE,
    EVAL
  } cs_state_e;

endpackage

// File: rtl/capsense_channel.sv
// One sensor lane: input synchronizer, rise-time latch, self-calibrated
// baseline, threshold compare and touch debounce.
module capsense_channel
  import capsense_pkg::*;
#(
  parameter int CNT_W     = CNT_W_D,
  parameter int THRESHOLD = THRESHOLD_D,
  parameter int DEBOUNCE  = DEBOUNCE_D
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sense_i,
  input  logic             clr_i,      // discharge phase: arm the latch
  input  logic             charge_i,   // charge phase: timing the rise
  input  logic             timeout_i,  // last charge cycle, cnt == MAX_COUNT
  input  logic             eval_i,
  input  logic             cal_i,      // still building the baseline
  input  logic [CNT_W-1:0] cnt_i,
  output logic             sync_o,
  output logic             hit_o,
  output logic [CNT_W-1:0] raw_o,
  output logic             touch_o
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);

  logic [1:0]       sync_q;
  logic             latched;
  logic [CNT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] baseline;
  logic [DB_W-1:0]  db_cnt;
  logic             touched;

  assign sync_o = sync_q[1];
  // A pin counts as done either once latched or when it is high right now,
  // so the FSM can leave CHARGE in the same cycle the last pin latches.
  assign hit_o  = latched | sync_o;
  // Sum is one bit wider so a near-full baseline cannot wrap below count.
  assign touched = ({1'b0, lat_cnt} >
                    ({1'b0, baseline} + (CNT_W+1)'(THRESHOLD)));

  // Two-flop synchronizer for the asynchronous sensor pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[0], sense_i};
  end

  // Capture cnt on the first high cycle; at timeout cnt already equals MAX_COUNT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latched <= 1'b0;
      lat_cnt <= '0;
    end else if (clr_i) begin
      latched <= 1'b0;
    end else if (charge_i && !latched && (sync_o || timeout_i)) begin
      latched <= 1'b1;
      lat_cnt <= cnt_i;
    end
  end

  // Scan result: publish count, then either track the minimum or debounce.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raw_o    <= '0;
      baseline <= '1;
      db_cnt   <= '0;
      touch_o  <= 1'b0;
    end else if (eval_i) begin
      raw_o <= lat_cnt;
      if (cal_i) begin
        if (lat_cnt < baseline) baseline <= lat_cnt;
      end else if (touched != touch_o) begin
        if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
          touch_o <= ~touch_o;
          db_cnt  <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/capsense_reader.sv
// Capacitive-touch receive path: drives the shared charge pin, times each
// sensor's RC rise and reports debounced touch state per sensor.
module capsense_reader
  import capsense_pkg::*;
#(
  parameter int NUM_SENSE    = NUM_SENSE_D,
  parameter int CNT_W        = CNT_W_D,
  parameter int DISCH_CYCLES = DISCH_CYCLES_D,
  parameter int MAX_COUNT    = MAX_COUNT_D,
  parameter int CAL_SCANS    = CAL_SCANS_D,
  parameter int THRESHOLD    = THRESHOLD_D,
  parameter int DEBOUNCE     = DEBOUNCE_D
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable_i,
  input  logic [NUM_SENSE-1:0]       sense_i,
  output logic                       charge_o,
  output logic [NUM_SENSE-1:0]       touch_o,
  output logic [NUM_SENSE*CNT_W-1:0] raw_count_o,
  output logic                       cal_done_o,
  output logic                       scan_done_o
);

  localparam int CAL_W = cal_w(CAL_SCANS);

  cs_state_e            state, next_state;
  logic [CNT_W-1:0]     cnt;
  logic [CAL_W-1:0]     cal_cnt;
  logic [NUM_SENSE-1:0] sync, hit;
  logic                 disch_done, timeout, calibrating;
  logic                 ch_clr, ch_charge, ch_eval;

  assign disch_done  = (cnt >= CNT_W'(DISCH_CYCLES - 1));
  assign timeout     = (cnt == CNT_W'(MAX_COUNT));
  assign calibrating = (cal_cnt != CAL_W'(CAL_SCANS));
  assign cal_done_o  = ~calibrating;

  // State register; charge_o is registered off the next state so it is glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      charge_o <= 1'b0;
    end else begin
      state    <= next_state;
      charge_o <= (next_state == CHARGE);
    end
  end

  // Next state; dropping enable aborts any scan that has not reached EVAL.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (enable_i) next_state = DISCHARGE;
      DISCHARGE: if (!enable_i)                     next_state = IDLE;
                 else if (disch_done && ~|sync)     next_state = CHARGE;
      CHARGE:    if (!enable_i)                     next_state = IDLE;
                 else if ((&hit) || timeout)        next_state = EVAL;
      EVAL:      next_state = enable_i ? DISCHARGE : IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Per-phase strobes to the channels and the scan-done pulse.
  always_comb begin
    ch_clr      = 1'b0;
    ch_charge   = 1'b0;
    ch_eval     = 1'b0;
    scan_done_o = 1'b0;
    case (state)
      DISCHARGE: ch_clr    = 1'b1;
      CHARGE:    ch_charge = 1'b1;
      EVAL: begin
        ch_eval     = 1'b1;
        scan_done_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Shared cycle counter: restarts on every phase change; the discharge
  // count saturates so a stuck pin can hold DISCHARGE indefinitely.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    cnt <= '0;
    else if (next_state != state)    cnt <= '0;
    else if (state == CHARGE ||
             (state == DISCHARGE && !disch_done))
                                     cnt <= cnt + 1'b1;
  end

  // Count completed scans until the baseline is valid; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   cal_cnt <= '0;
    else if (ch_eval && calibrating) cal_cnt <= cal_cnt + 1'b1;
  end

  for (genvar g = 0; g < NUM_SENSE; g++) begin : g_ch
    capsense_channel #(
      .CNT_W     (CNT_W),
      .THRESHOLD (THRESHOLD),
      .DEBOUNCE  (DEBOUNCE)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .sense_i   (sense_i[g]),
      .clr_i     (ch_clr),
      .charge_i  (ch_charge),
      .timeout_i (timeout),
      .eval_i    (ch_eval),
      .cal_i     (calibrating),
      .cnt_i     (cnt),
      .sync_o    (sync[g]),
      .hit_o     (hit[g]),
      .raw_o     (raw_count_o[g*CNT_W +: CNT_W]),
      .touch_o   (touch_o[g])
    );
  end

endmodule
